// File: rtl/riscv_irq_timer.sv
// rtl/riscv_irq_timer.sv - machine timer plus external interrupt aggregator driving one-cycle irq pulses
//
// Purpose: 64-bit mtime/mtimecmp timer and a pending/enable/claim aggregator
// for NUM_SRC external sources. Interrupts reach the core as single-cycle
// pulses, and the two pulse outputs are never high together.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   irq_src        external request levels (synchronous to clk), rising edge latches pending
//   bus_sel/we     one-cycle register access strobe, 1 = write
//   bus_addr       word offset: 0 MTIME_LO 1 MTIME_HI 2 MTIMECMP_LO 3 MTIMECMP_HI
//                  4 PENDING 5 ENABLE 6 CLAIM 7 CTRL
//   bus_wdata      write data
//   bus_rdata      read data, valid while bus_ack=1
//   bus_ack        registered copy of bus_sel
//   hardware_irq   one-cycle external interrupt pulse
//   timer_irq      one-cycle timer interrupt pulse
module riscv_irq_timer #(
  parameter int NUM_SRC  = 8,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_sel,
  input  logic               bus_we,
  input  logic [2:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               hardware_irq,
  output logic               timer_irq
);

  localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADDR_PENDING     = 3'd4;
  localparam logic [2:0] ADDR_ENABLE      = 3'd5;
  localparam logic [2:0] ADDR_CLAIM       = 3'd6;
  localparam logic [2:0] ADDR_CTRL        = 3'd7;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] irq_src_q;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               hw_armed_q, hw_armed_d;
  logic               tm_armed_q, tm_armed_d;
  logic               tm_defer_q, tm_defer_d;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               hw_irq_q, hw_irq_d;
  logic               tm_irq_q, tm_irq_d;

  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] claim_mask;
  logic [4:0]         claim_id;
  logic               hw_due;
  logic               tm_due;
  logic               bus_wr;
  logic               bus_rd;

  assign active = pending_q & enable_q;
  assign rise   = irq_src & ~irq_src_q;
  assign bus_wr = bus_sel & bus_we;
  assign bus_rd = bus_sel & ~bus_we;
  assign hw_due = hw_armed_q & (|active);
  // A deferred timer pulse stays owed only while the timer interrupt is enabled.
  assign tm_due = ctrl_q[1] & (tm_defer_q | (tm_armed_q & (mtime_q >= mtimecmp_q)));

  // Lowest-index active source; scanning high to low lets the lowest overwrite.
  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_id      = 5'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    pending_d  = pending_q;
    enable_d   = enable_q;
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    hw_armed_d = hw_armed_q;
    tm_armed_d = tm_armed_q;
    rdata_d    = '0;

    if (ctrl_q[0]) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Hardware wins a collision; the timer pulse is carried in tm_defer.
    hw_irq_d   = hw_due;
    tm_irq_d   = tm_due & ~hw_due;
    tm_defer_d = tm_due & hw_due;
    if (hw_due) hw_armed_d = 1'b0;
    if (tm_due) tm_armed_d = 1'b0;

    if (bus_rd) begin
      case (bus_addr)
        ADDR_MTIME_LO:    rdata_d = mtime_q[31:0];
        ADDR_MTIME_HI:    rdata_d = mtime_q[63:32];
        ADDR_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        ADDR_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        ADDR_PENDING:     rdata_d = 32'(pending_q);
        ADDR_ENABLE:      rdata_d = 32'(enable_q);
        ADDR_CLAIM: begin
          rdata_d    = 32'(claim_id);
          pending_d  = pending_q & ~claim_mask;
          hw_armed_d = 1'b1;
        end
        ADDR_CTRL:        rdata_d = 32'(ctrl_q);
      endcase
    end

    // Half writes replace only their half and suppress the increment, so no carry leaks across.
    if (bus_wr) begin
      case (bus_addr)
        ADDR_MTIME_LO:    mtime_d = {mtime_q[63:32], bus_wdata};
        ADDR_MTIME_HI:    mtime_d = {bus_wdata, mtime_q[31:0]};
        ADDR_MTIMECMP_LO: begin
          mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
          tm_armed_d = 1'b1;
        end
        ADDR_MTIMECMP_HI: begin
          mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
          tm_armed_d = 1'b1;
        end
        ADDR_PENDING:     pending_d = pending_q & ~bus_wdata[NUM_SRC-1:0];
        ADDR_ENABLE:      enable_d  = bus_wdata[NUM_SRC-1:0];
        ADDR_CLAIM:       ;
        ADDR_CTRL: begin
          ctrl_d     = bus_wdata[1:0];
          tm_armed_d = 1'b1;
        end
      endcase
    end

    // Applied last so a new edge beats a same-cycle clear.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      pending_q  <= '0;
      enable_q   <= '0;
      irq_src_q  <= '0;
      ctrl_q     <= '0;
      presc_q    <= '0;
      hw_armed_q <= 1'b1;
      tm_armed_q <= 1'b0;
      tm_defer_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      hw_irq_q   <= 1'b0;
      tm_irq_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_src_q  <= irq_src;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      hw_armed_q <= hw_armed_d;
      tm_armed_q <= tm_armed_d;
      tm_defer_q <= tm_defer_d;
      ack_q      <= bus_sel;
      rdata_q    <= rdata_d;
      hw_irq_q   <= hw_irq_d;
      tm_irq_q   <= tm_irq_d;
    end
  end

  assign bus_rdata    = rdata_q;
  assign bus_ack      = ack_q;
  assign hardware_irq = hw_irq_q;
  assign timer_irq    = tm_irq_q;

endmodule

// File: tb/tb_riscv_irq_timer.sv
// tb/tb_riscv_irq_timer.sv - randomized and directed self-checking bench for riscv_irq_timer
module tb_riscv_irq_timer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] rdata0, rdata4;
  logic        ack0, ack4, hw0, hw4, tm0, tm4;

  riscv_irq_timer #(.NUM_SRC(8), .PRESCALE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(rdata0), .bus_ack(ack0), .hardware_irq(hw0), .timer_irq(tm0)
  );

  riscv_irq_timer #(.NUM_SRC(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(rdata4), .bus_ack(ack4), .hardware_irq(hw4), .timer_irq(tm4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [7:0]  pend;
    logic [7:0]  en;
    logic [7:0]  src_q;
    logic [1:0]  ctrl;
    logic [31:0] ticks;
    logic        hw_armed;
    logic        tm_armed;
    logic        tm_defer;
    logic        hw;
    logic        tm;
    logic        ack;
    logic [31:0] rdata;
  } mdl_t;

  mdl_t m0, m4;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   hw_cnt = 0, tm_cnt = 0, hw_cyc = -1, tm_cyc = -1;
  int   w;
  logic [31:0] r0, r4;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s = '0;
    s.cmp = '1;
    s.hw_armed = 1'b1;
    return s;
  endfunction

  // One clock of the register-level behaviour: outputs are what becomes visible after the edge.
  function automatic mdl_t step(mdl_t s, int pre, logic sel, logic we, logic [2:0] a,
                                logic [31:0] d, logic [7:0] src);
    mdl_t n;
    logic [7:0] act;
    logic hw_due, tm_due;
    int id;
    n = s;
    act = s.pend & s.en;
    hw_due = s.hw_armed && (act != 8'd0);
    tm_due = s.ctrl[1] && (s.tm_defer || (s.tm_armed && (s.mtime >= s.cmp)));
    n.hw = hw_due;
    n.tm = tm_due && !hw_due;
    n.tm_defer = tm_due && hw_due;
    if (hw_due) n.hw_armed = 1'b0;
    if (tm_due) n.tm_armed = 1'b0;
    if (s.ctrl[0]) begin
      n.ticks = s.ticks + 32'd1;
      if (n.ticks % pre == 0) n.mtime = s.mtime + 64'd1;
    end
    id = 0;
    for (int i = 7; i >= 0; i--) if (act[i]) id = i + 1;
    n.ack = sel;
    n.rdata = 32'd0;
    if (sel && !we) begin
      case (a)
        3'd0: n.rdata = s.mtime[31:0];
        3'd1: n.rdata = s.mtime[63:32];
        3'd2: n.rdata = s.cmp[31:0];
        3'd3: n.rdata = s.cmp[63:32];
        3'd4: n.rdata = {24'd0, s.pend};
        3'd5: n.rdata = {24'd0, s.en};
        3'd6: begin
          n.rdata = 32'(id);
          if (id != 0) n.pend[id-1] = 1'b0;
          n.hw_armed = 1'b1;
        end
        3'd7: n.rdata = {30'd0, s.ctrl};
      endcase
    end
    if (sel && we) begin
      case (a)
        3'd0: n.mtime = {s.mtime[63:32], d};
        3'd1: n.mtime = {d, s.mtime[31:0]};
        3'd2: begin n.cmp = {s.cmp[63:32], d}; n.tm_armed = 1'b1; end
        3'd3: begin n.cmp = {d, s.cmp[31:0]}; n.tm_armed = 1'b1; end
        3'd4: n.pend = s.pend & ~d[7:0];
        3'd5: n.en = d[7:0];
        3'd6: ;
        3'd7: begin n.ctrl = d[1:0]; n.tm_armed = 1'b1; end
      endcase
    end
    n.pend = n.pend | (src & ~s.src_q);
    n.src_q = src;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m0 = mdl_reset();
      m4 = mdl_reset();
    end else begin
      m0 = step(m0, 1, bus_sel, bus_we, bus_addr, bus_wdata, irq_src);
      m4 = step(m4, 4, bus_sel, bus_we, bus_addr, bus_wdata, irq_src);
    end
    cyc++;
    #1;
    chk("hw_irq", 64'(hw0), 64'(m0.hw));
    chk("tm_irq", 64'(tm0), 64'(m0.tm));
    chk("ack", 64'(ack0), 64'(m0.ack));
    if (m0.ack) chk("rdata", 64'(rdata0), 64'(m0.rdata));
    chk("hw_irq_p4", 64'(hw4), 64'(m4.hw));
    chk("tm_irq_p4", 64'(tm4), 64'(m4.tm));
    if (m4.ack) chk("rdata_p4", 64'(rdata4), 64'(m4.rdata));
    chk("excl", 64'(hw0 & tm0), 64'd0);
    if (hw0) begin hw_cnt++; hw_cyc = cyc; end
    if (tm0) begin tm_cnt++; tm_cyc = cyc; end
  endtask

  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] o0, output logic [31:0] o4);
    bus_sel = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    tick();
    o0 = rdata0;
    o4 = rdata4;
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] x0, x4;
    bus(1'b1, a, d, x0, x4);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd_;
    logic        rwe;
    rst_n = 1'b0; irq_src = '0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    m0 = mdl_reset(); m4 = mdl_reset();
    tick(); tick();
    chk("rst_hw", 64'(hw0), 64'd0);
    chk("rst_ack", 64'(ack0), 64'd0);
    chk("rst_rdata", 64'(rdata0), 64'd0);
    rst_n = 1'b1;
    bus(1'b0, 3'd0, 0, r0, r4); chk("rst_mtime_lo", 64'(r0), 64'd0);
    bus(1'b0, 3'd2, 0, r0, r4); chk("rst_cmp_lo", 64'(r0), 64'hFFFF_FFFF);
    bus(1'b0, 3'd3, 0, r0, r4); chk("rst_cmp_hi", 64'(r0), 64'hFFFF_FFFF);
    bus(1'b0, 3'd4, 0, r0, r4); chk("rst_pending", 64'(r0), 64'd0);

    // Timer: single pulse the cycle after mtime reaches 10, no repeat.
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    tm_cnt = 0;
    wr(3'd7, 32'd3);
    w = cyc;
    bus(1'b0, 3'd0, 0, r0, r4); chk("t1_mtime0", 64'(r0), 64'd0);
    bus(1'b0, 3'd0, 0, r0, r4); chk("t1_mtime1", 64'(r0), 64'd1);
    repeat (30) tick();
    chk("t1_tm_count", 64'(tm_cnt), 64'd1);
    chk("t1_tm_cycle", 64'(tm_cyc), 64'(w + 11));
    wr(3'd7, 32'd1);

    // Claim sequence with two simultaneous edges.
    wr(3'd5, 32'h05);
    hw_cnt = 0;
    irq_src = 8'h05;
    repeat (3) tick();
    chk("t2_hw_first", 64'(hw_cnt), 64'd1);
    bus(1'b0, 3'd6, 0, r0, r4); chk("t2_claim1", 64'(r0), 64'd1);
    repeat (2) tick();
    chk("t2_hw_second", 64'(hw_cnt), 64'd2);
    bus(1'b0, 3'd6, 0, r0, r4); chk("t2_claim3", 64'(r0), 64'd3);
    repeat (3) tick();
    chk("t2_hw_none", 64'(hw_cnt), 64'd2);
    bus(1'b0, 3'd6, 0, r0, r4); chk("t2_claim0", 64'(r0), 64'd0);
    irq_src = 8'h00;
    tick();

    // Collision: hardware first, timer one cycle later.
    wr(3'd7, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd7, 32'd3);
    w = cyc;
    repeat (4) tick();
    irq_src = 8'h01;
    hw_cnt = 0; tm_cnt = 0;
    repeat (4) tick();
    chk("t3_hw_cycle", 64'(hw_cyc), 64'(w + 6));
    chk("t3_tm_cycle", 64'(tm_cyc), 64'(w + 7));
    chk("t3_hw_count", 64'(hw_cnt), 64'd1);
    chk("t3_tm_count", 64'(tm_cnt), 64'd1);
    bus(1'b0, 3'd6, 0, r0, r4); chk("t3_claim", 64'(r0), 64'd1);
    irq_src = 8'h00;

    // Set beats W1C; disabled pending waits for ENABLE.
    wr(3'd5, 32'd0);
    tick();
    irq_src = 8'h02;
    wr(3'd4, 32'h2);
    bus(1'b0, 3'd4, 0, r0, r4); chk("t5_pending", 64'(r0), 64'h2);
    hw_cnt = 0;
    repeat (5) tick();
    chk("t5_hw_masked", 64'(hw_cnt), 64'd0);
    wr(3'd5, 32'h02);
    w = cyc;
    tick();
    chk("t5_hw_count", 64'(hw_cnt), 64'd1);
    chk("t5_hw_cycle", 64'(hw_cyc), 64'(w + 1));

    // Asynchronous reset while timer_irq is high.
    wr(3'd7, 32'd1);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd7, 32'd3);
    tick();
    chk("t6_tm_before", 64'(tm0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tm_async", 64'(tm0), 64'd0);
    chk("t6_hw_async", 64'(hw0), 64'd0);
    chk("t6_tm4_async", 64'(tm4), 64'd0);
    tick();
    rst_n = 1'b1;
    irq_src = 8'h00;
    bus(1'b0, 3'd0, 0, r0, r4); chk("t6_mtime_lo", 64'(r0), 64'd0);
    bus(1'b0, 3'd1, 0, r0, r4); chk("t6_mtime_hi", 64'(r0), 64'd0);
    bus(1'b0, 3'd2, 0, r0, r4); chk("t6_cmp_lo", 64'(r0), 64'hFFFF_FFFF);
    bus(1'b0, 3'd3, 0, r0, r4); chk("t6_cmp_hi", 64'(r0), 64'hFFFF_FFFF);

    // Prescaled carry from low to high half.
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'd0);
    wr(3'd7, 32'd1);
    repeat (4) tick();
    bus(1'b0, 3'd1, 0, r0, r4); chk("t4_hi_p4", 64'(r4), 64'd1);
    bus(1'b0, 3'd0, 0, r0, r4); chk("t4_lo_p4", 64'(r4), 64'd0);

    // Random traffic against the model.
    wr(3'd5, 32'hFF);
    wr(3'd7, 32'd3);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) irq_src = irq_src ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 99) < 40) begin
        ra  = 3'($urandom_range(0, 7));
        rwe = 1'($urandom_range(0, 1));
        case (ra)
          3'd0:    rd_ = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
          3'd1:    rd_ = 32'($urandom_range(0, 1));
          3'd2:    rd_ = m0.mtime[31:0] + 32'($urandom_range(0, 20)) - 32'd5;
          3'd3:    rd_ = m0.mtime[63:32];
          3'd7:    rd_ = 32'($urandom_range(0, 3));
          default: rd_ = $urandom;
        endcase
        bus(rwe, ra, rd_, r0, r4);
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
